// File: rtl/tap_pkg.sv
// Shared definitions for the TAP cassette playback controller.
// Holds the FSM state encoding, the default bit-encoding timings, the TAP
// download index, and small helpers used by the playback engine.
package tap_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ST_W   = 3;

    typedef logic [ST_W-1:0] tap_state_t;

    localparam tap_state_t ST_IDLE   = 3'd0;
    localparam tap_state_t ST_LOAD   = 3'd1;
    localparam tap_state_t ST_READY  = 3'd2;
    localparam tap_state_t ST_LEADER = 3'd3;
    localparam tap_state_t ST_SYNC   = 3'd4;
    localparam tap_state_t ST_DATA   = 3'd5;
    localparam tap_state_t ST_TAIL   = 3'd6;

    localparam logic [7:0]       TAP_INDEX   = 8'd1;
    localparam logic [CNT_W-1:0] T0_HALF     = 16'd1600;
    localparam logic [CNT_W-1:0] T1_HALF     = 16'd3200;
    localparam logic [CNT_W-1:0] LEADER_BITS = 16'd768;

    // States in which the playback engine owns the EAR line.
    function automatic logic is_playing(input tap_state_t s);
        return (s == ST_LEADER) || (s == ST_SYNC) || (s == ST_DATA) || (s == ST_TAIL);
    endfunction

    // Down-counter reload value for one half period of the given bit.
    function automatic logic [CNT_W-1:0] half_reload(input logic b,
                                                     input logic [CNT_W-1:0] t0,
                                                     input logic [CNT_W-1:0] t1);
        return b ? (t1 - 16'd1) : (t0 - 16'd1);
    endfunction

endpackage

// File: rtl/tap_buffer.sv
// Byte buffer holding the downloaded TAP image.
// Simple dual-port RAM, 2^ADDR_W bytes: one write port, one read port whose
// data is registered (1-cycle read latency). No reset, so it maps to block RAM.
// Ports:
//   clk_i                 clock
//   wr_en_i/wr_addr_i/wr_data_i   write port
//   rd_addr_i             read address
//   rd_data_o             registered read data
module tap_buffer #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o
);
    import tap_pkg::*;

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [BYTE_W-1:0] mem_q [DEPTH];

    // Write port and registered read port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/tap_playback_ctrl.sv
// Cassette playback controller: captures a TAP image from the HPS download
// channel into a byte buffer, replays it as a bit-serial EAR square wave
// (leader of 0 bits, one sync 1 bit, data bytes MSB first, low tail), and
// arbitrates EAR between the playback engine and the ADC tape path.
// Build option: TAP_AUTOPLAY_EN starts playback automatically when a
// non-empty download completes.
// Ports:
//   clk_sys, reset                       clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/data    HPS download channel
//   play, stop                           single-cycle start / abort pulses
//   pause                                level, freezes playback
//   adc_ear, adc_act                     ADC tape comparator and activity flag
//   ear                                  arbitrated EAR bit
//   playing                              engine owns EAR
//   loaded                               non-empty image in the buffer
//   overflow                             last download exceeded buffer depth
module tap_playback_ctrl #(
    parameter int unsigned ADDR_W      = 16,
    parameter logic [7:0]  TAP_INDEX   = tap_pkg::TAP_INDEX,
    parameter logic [15:0] T0_HALF     = tap_pkg::T0_HALF,
    parameter logic [15:0] T1_HALF     = tap_pkg::T1_HALF,
    parameter logic [15:0] LEADER_BITS = tap_pkg::LEADER_BITS
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        play,
    input  logic        stop,
    input  logic        pause,
    input  logic        adc_ear,
    input  logic        adc_act,
    output logic        ear,
    output logic        playing,
    output logic        loaded,
    output logic        overflow
);
    import tap_pkg::*;

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] TAIL_CNT = 16'((32'(T1_HALF) << 1) - 32'd1);

    tap_state_t       state_q,  state_d;
    logic             tape_q,   tape_d;
    logic             phase_q,  phase_d;   // 0: high half, 1: low half
    logic             bit_q,    bit_d;     // value of the bit being emitted
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] lead_q,   lead_d;    // leader bits still to emit after this one
    logic [2:0]       bidx_q,   bidx_d;
    logic [7:0]       sh_q,     sh_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] length_q, length_d;
    logic             ovf_q,    ovf_d;
    logic             loaded_q, loaded_d;
    logic             ear_q,    ear_d;
    logic             play_q,   play_d;

    logic             dl_start_c;
    logic             in_range_c;
    logic [LEN_W-1:0] wr_len_c;
    logic             wr_en_c;
    logic             start_bit_c;
    logic             next_bit_c;
    logic [7:0]       rd_data;

    tap_buffer #(
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk_i     (clk_sys),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (ioctl_addr[ADDR_W-1:0]),
        .wr_data_i (ioctl_data),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_data_o (rd_data)
    );

    assign dl_start_c = ioctl_download && (ioctl_index == TAP_INDEX);
    assign in_range_c = (ioctl_addr >> ADDR_W) == 25'd0;
    assign wr_len_c   = LEN_W'(ioctl_addr[ADDR_W-1:0]) + LEN_W'(1);

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        tape_d      = tape_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        lead_d      = lead_q;
        bidx_d      = bidx_q;
        sh_d        = sh_q;
        rd_ptr_d    = rd_ptr_q;
        length_d    = length_q;
        ovf_d       = ovf_q;
        wr_en_c     = 1'b0;
        start_bit_c = 1'b0;
        next_bit_c  = 1'b0;

        if (dl_start_c && (state_q != ST_LOAD)) begin
            // A new TAP download aborts whatever is going on.
            state_d  = ST_LOAD;
            length_d = '0;
            ovf_d    = 1'b0;
            tape_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (ioctl_download) begin
                        if (ioctl_wr) begin
                            if (in_range_c) begin
                                wr_en_c = 1'b1;
                                if (wr_len_c > length_q) begin
                                    length_d = wr_len_c;
                                end
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end else if (length_q != '0) begin
`ifdef TAP_AUTOPLAY_EN
                        state_d     = ST_LEADER;
                        rd_ptr_d    = '0;
                        bidx_d      = '0;
                        lead_d      = LEADER_BITS - 16'd1;
                        start_bit_c = 1'b1;
`else
                        state_d = ST_READY;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_READY: begin
                    if (play && !stop) begin
                        state_d     = ST_LEADER;
                        rd_ptr_d    = '0;
                        bidx_d      = '0;
                        lead_d      = LEADER_BITS - 16'd1;
                        start_bit_c = 1'b1;
                    end
                end

                ST_LEADER, ST_SYNC, ST_DATA, ST_TAIL: begin
                    if (stop) begin
                        state_d = ST_READY;
                        tape_d  = 1'b0;
                    end else if (!pause) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 16'd1;
                        end else if (state_q == ST_TAIL) begin
                            state_d = ST_READY;
                        end else if (!phase_q) begin
                            phase_d = 1'b1;
                            tape_d  = 1'b0;
                            cnt_d   = half_reload(bit_q, T0_HALF, T1_HALF);
                        end else begin
                            // Bit complete: pick the next bit or leave the state.
                            case (state_q)
                                ST_LEADER: begin
                                    start_bit_c = 1'b1;
                                    if (lead_q == '0) begin
                                        state_d    = ST_SYNC;
                                        next_bit_c = 1'b1;
                                    end else begin
                                        lead_d = lead_q - 16'd1;
                                    end
                                end
                                ST_SYNC: begin
                                    // Byte 0 has been sitting on the read port since play.
                                    state_d     = ST_DATA;
                                    start_bit_c = 1'b1;
                                    next_bit_c  = rd_data[7];
                                    sh_d        = {rd_data[6:0], 1'b0};
                                    bidx_d      = '0;
                                    rd_ptr_d    = rd_ptr_q + LEN_W'(1);
                                end
                                default: begin
                                    if (bidx_q != 3'd7) begin
                                        start_bit_c = 1'b1;
                                        next_bit_c  = sh_q[7];
                                        sh_d        = {sh_q[6:0], 1'b0};
                                        bidx_d      = bidx_q + 3'd1;
                                    end else if (rd_ptr_q == length_q) begin
                                        state_d = ST_TAIL;
                                        tape_d  = 1'b0;
                                        cnt_d   = TAIL_CNT;
                                    end else begin
                                        // Next byte was prefetched while this byte played.
                                        start_bit_c = 1'b1;
                                        next_bit_c  = rd_data[7];
                                        sh_d        = {rd_data[6:0], 1'b0};
                                        bidx_d      = '0;
                                        rd_ptr_d    = rd_ptr_q + LEN_W'(1);
                                    end
                                end
                            endcase
                        end
                    end
                end

                default: ;
            endcase
        end

        // Every bit starts with its high half.
        if (start_bit_c) begin
            tape_d  = 1'b1;
            phase_d = 1'b0;
            bit_d   = next_bit_c;
            cnt_d   = half_reload(next_bit_c, T0_HALF, T1_HALF);
        end

        play_d   = is_playing(state_d);
        ear_d    = play_d ? tape_d : (adc_act & adc_ear);
        loaded_d = (state_q != ST_LOAD) && (length_q != '0);
    end

    // State and datapath registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tape_q   <= 1'b0;
            phase_q  <= 1'b0;
            bit_q    <= 1'b0;
            cnt_q    <= '0;
            lead_q   <= '0;
            bidx_q   <= '0;
            sh_q     <= '0;
            rd_ptr_q <= '0;
            length_q <= '0;
            ovf_q    <= 1'b0;
            loaded_q <= 1'b0;
            ear_q    <= 1'b0;
            play_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tape_q   <= tape_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            lead_q   <= lead_d;
            bidx_q   <= bidx_d;
            sh_q     <= sh_d;
            rd_ptr_q <= rd_ptr_d;
            length_q <= length_d;
            ovf_q    <= ovf_d;
            loaded_q <= loaded_d;
            ear_q    <= ear_d;
            play_q   <= play_d;
        end
    end

    assign ear      = ear_q;
    assign playing  = play_q;
    assign loaded   = loaded_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_tap_playback_ctrl.sv
// Directed self-checking bench for tap_playback_ctrl
// (ADDR_W=4, T0_HALF=4, T1_HALF=8, LEADER_BITS=2).
module tb_tap_playback_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_data = 8'd0;
    logic        play = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic        adc_ear = 1'b0;
    logic        adc_act = 1'b0;
    logic        ear;
    logic        playing;
    logic        loaded;
    logic        overflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [24:0] dl_addr [4];
    logic [7:0]  dl_data [4];
    logic [7:0]  img [3];
    logic        exp_q [$];

    tap_playback_ctrl #(
        .ADDR_W      (4),
        .TAP_INDEX   (8'd1),
        .T0_HALF     (16'd4),
        .T1_HALF     (16'd8),
        .LEADER_BITS (16'd2)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .play           (play),
        .stop           (stop),
        .pause          (pause),
        .adc_ear        (adc_ear),
        .adc_act        (adc_act),
        .ear            (ear),
        .playing        (playing),
        .loaded         (loaded),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_bit(input logic v);
        int h;
        h = v ? 8 : 4;
        repeat (h) exp_q.push_back(1'b1);
        repeat (h) exp_q.push_back(1'b0);
    endtask

    task automatic build_wave;
        logic [7:0] b;
        exp_q.delete();
        push_bit(1'b0);
        push_bit(1'b0);
        push_bit(1'b1);
        for (int j = 0; j < 3; j++) begin
            b = img[j];
            for (int k = 7; k >= 0; k--) push_bit(b[k]);
        end
        repeat (16) exp_q.push_back(1'b0);
    endtask

    task automatic download(input logic [7:0] idx, input int n);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick;
        for (int j = 0; j < n; j++) begin
            ioctl_addr = dl_addr[j];
            ioctl_data = dl_data[j];
            ioctl_wr   = 1'b1;
            tick;
            ioctl_wr   = 1'b0;
            tick;
        end
        ioctl_download = 1'b0;
        tick;
    endtask

    // Pulse play and compare EAR cycle by cycle against exp_q; optional pause.
    task automatic play_and_check(input string tag, input int pause_at);
        int   errs;
        int   first;
        logic got;
        logic want;
        errs  = 0;
        first = -1;
        got   = 1'b0;
        want  = 1'b0;
        play = 1'b1;
        tick;
        play = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (ear !== exp_q[i] || playing !== 1'b1) begin
                if (errs == 0) begin first = i; got = ear; want = exp_q[i]; end
                errs++;
            end
            if (i == pause_at) begin
                pause = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    tick;
                    if (ear !== exp_q[i] || playing !== 1'b1) begin
                        if (errs == 0) begin first = i; got = ear; want = exp_q[i]; end
                        errs++;
                    end
                end
                pause = 1'b0;
            end
            tick;
        end
        total_cnt++;
        if (errs != 0)
            $display("FAIL %s_wave: %0d bad samples, first at %0d ear=%0b expected %0b",
                     tag, errs, first, got, want);
        else pass_cnt++;
        total_cnt++;
        if (playing !== 1'b0) $display("FAIL %s_end_playing: got %0b expected 0", tag, playing);
        else pass_cnt++;
        total_cnt++;
        if (ear !== 1'b0) $display("FAIL %s_end_ear: got %0b expected 0", tag, ear);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        total_cnt++;
        if ({ear, playing, loaded, overflow} !== 4'b0000)
            $display("FAIL reset_outputs: got %b expected 0000", {ear, playing, loaded, overflow});
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== tap_pkg::ST_IDLE)
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, tap_pkg::ST_IDLE);
        else pass_cnt++;
        total_cnt++;
        if (dut.length_q !== 5'd0) $display("FAIL reset_length: got %0d expected 0", dut.length_q);
        else pass_cnt++;
    endtask

    task automatic test_adc;
        adc_act = 1'b1; adc_ear = 1'b1;
        tick;
        total_cnt++;
        if (ear !== 1'b1) $display("FAIL adc_follow_1: got %0b expected 1", ear);
        else pass_cnt++;
        adc_ear = 1'b0;
        tick;
        total_cnt++;
        if (ear !== 1'b0) $display("FAIL adc_follow_0: got %0b expected 0", ear);
        else pass_cnt++;
        adc_act = 1'b0; adc_ear = 1'b1;
        tick;
        total_cnt++;
        if (ear !== 1'b0) $display("FAIL adc_inactive: got %0b expected 0", ear);
        else pass_cnt++;
        adc_ear = 1'b0;
    endtask

    task automatic test_download;
        int waited;
        dl_addr[0] = 25'd0; dl_data[0] = 8'hA5;
        dl_addr[1] = 25'd1; dl_data[1] = 8'h00;
        dl_addr[2] = 25'd2; dl_data[2] = 8'hFF;
        download(8'd1, 3);
        total_cnt++;
        if (loaded !== 1'b0) $display("FAIL dl_loaded_lag: got %0b expected 0", loaded);
        else pass_cnt++;
        total_cnt++;
        if (dut.length_q !== 5'd3) $display("FAIL dl_length: got %0d expected 3", dut.length_q);
        else pass_cnt++;
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL dl_overflow: got %0b expected 0", overflow);
        else pass_cnt++;
`ifdef TAP_AUTOPLAY_EN
        total_cnt++;
        if (playing !== 1'b1) $display("FAIL dl_autoplay: got %0b expected 1", playing);
        else pass_cnt++;
        waited = 0;
        while (playing === 1'b1 && waited < 2000) begin tick; waited++; end
        total_cnt++;
        if (playing !== 1'b0) $display("FAIL dl_autoplay_end: got %0b expected 0", playing);
        else pass_cnt++;
`else
        waited = 0;
        total_cnt++;
        if (dut.state_q !== tap_pkg::ST_READY || playing !== 1'b0)
            $display("FAIL dl_ready: state %0d playing %0b expected state %0d playing 0",
                     dut.state_q, playing, tap_pkg::ST_READY);
        else pass_cnt++;
`endif
        tick;
        total_cnt++;
        if (loaded !== 1'b1) $display("FAIL dl_loaded: got %0b expected 1 (waited %0d)", loaded, waited);
        else pass_cnt++;
    endtask

    task automatic test_stop;
        play = 1'b1;
        tick;
        play = 1'b0;
        repeat (50) tick;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        total_cnt++;
        if (ear !== 1'b0 || playing !== 1'b0)
            $display("FAIL stop_outputs: ear %0b playing %0b expected 0 0", ear, playing);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== tap_pkg::ST_READY)
            $display("FAIL stop_state: got %0d expected %0d", dut.state_q, tap_pkg::ST_READY);
        else pass_cnt++;
        tick;
        play_and_check("restart", -1);
    endtask

    task automatic test_play_stop_same;
        play = 1'b1;
        stop = 1'b1;
        tick;
        play = 1'b0;
        stop = 1'b0;
        total_cnt++;
        if (playing !== 1'b0) $display("FAIL play_stop_same: got %0b expected 0", playing);
        else pass_cnt++;
    endtask

    task automatic test_other_index;
        dl_addr[0] = 25'd0; dl_data[0] = 8'h11;
        dl_addr[1] = 25'd1; dl_data[1] = 8'h22;
        download(8'd2, 2);
        total_cnt++;
        if (dut.state_q !== tap_pkg::ST_READY || dut.length_q !== 5'd3 || loaded !== 1'b1)
            $display("FAIL idx2_unchanged: state %0d length %0d loaded %0b expected %0d 3 1",
                     dut.state_q, dut.length_q, loaded, tap_pkg::ST_READY);
        else pass_cnt++;
        play_and_check("idx2", -1);
    endtask

    task automatic test_overflow;
        dl_addr[0] = 25'd0;  dl_data[0] = 8'h5A;
        dl_addr[1] = 25'd15; dl_data[1] = 8'h3C;
        dl_addr[2] = 25'd16; dl_data[2] = 8'h77;
        download(8'd1, 3);
        tick;
        total_cnt++;
        if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b expected 1", overflow);
        else pass_cnt++;
        total_cnt++;
        if (dut.length_q !== 5'd16) $display("FAIL ovf_length: got %0d expected 16", dut.length_q);
        else pass_cnt++;
        total_cnt++;
        if (loaded !== 1'b1) $display("FAIL ovf_loaded: got %0b expected 1", loaded);
        else pass_cnt++;
    endtask

    initial begin
        img[0] = 8'hA5;
        img[1] = 8'h00;
        img[2] = 8'hFF;
        build_wave;
        test_reset;
        test_adc;
        test_download;
        tick;
        play_and_check("play", -1);
        tick;
        play_and_check("pause", 35);
        tick;
        test_stop;
        tick;
        test_play_stop_same;
        test_other_index;
        test_overflow;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
